// File: rtl/ysyx_22051468_lut_pkg.sv
// ysyx_22051468_lut_pkg: shared index-width helper for the lookup table
package ysyx_22051468_lut_pkg;
  function automatic int clog2_min1(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ysyx_22051468_prio_enc.sv
// ysyx_22051468_prio_enc: multi-hot request -> {any, lowest set index}, idx=0 when none
module ysyx_22051468_prio_enc
  import ysyx_22051468_lut_pkg::*;
#(
  parameter int N = 4,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [W-1:0] idx
);
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
  end
endmodule

// File: rtl/ysyx_22051468_lookup_table.sv
// ysyx_22051468_lookup_table: writable key->data table with priority match and a one-deep handshaked result register
module ysyx_22051468_lookup_table
  import ysyx_22051468_lut_pkg::*;
#(
  parameter int NR_KEY = 4,
  parameter int KEY_LEN = 12,
  parameter int DATA_LEN = 32,
  parameter int HAS_DEFAULT = 1,
  localparam int IDX_LEN = clog2_min1(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                flush,
  input  logic                lk_valid,
  output logic                lk_ready,
  input  logic [KEY_LEN-1:0]  lk_key,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_LEN-1:0] res_data,
  output logic                res_hit,
  output logic [IDX_LEN-1:0]  res_idx
);
  typedef struct packed {
    logic                valid;
    logic [KEY_LEN-1:0]  key;
    logic [DATA_LEN-1:0] data;
  } entry_t;
  logic [NR_KEY-1:0] vld_q, vld_d, match;
  logic [KEY_LEN-1:0] key_q [NR_KEY];
  logic [KEY_LEN-1:0] key_d [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [DATA_LEN-1:0] data_d [NR_KEY];
  entry_t ent [NR_KEY];
  logic any, accept;
  logic [IDX_LEN-1:0] win;
  logic res_valid_q, res_valid_d, res_hit_q, res_hit_d;
  logic [IDX_LEN-1:0] res_idx_q, res_idx_d;
  logic [DATA_LEN-1:0] res_data_q, res_data_d;
  always_comb begin
    vld_d = flush ? '0 : vld_q;
    key_d = key_q;
    data_d = data_q;
    match = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      ent[i] = '{vld_q[i], key_q[i], data_q[i]};
      match[i] = ent[i].valid && ent[i].key == lk_key;
      if (wr_en && wr_idx == IDX_LEN'(i)) begin
        vld_d[i] = 1'b1;
        key_d[i] = wr_key;
        data_d[i] = wr_data;
      end
    end
  end
  ysyx_22051468_prio_enc #(.N(NR_KEY)) u_enc (
    .req(match),
    .any(any),
    .idx(win)
  );
  assign lk_ready = !res_valid_q || res_ready;
  assign accept = lk_valid && lk_ready;
  always_comb begin
    res_valid_d = accept || (res_valid_q && !res_ready);
    res_hit_d = accept ? any : res_hit_q;
    res_idx_d = accept ? win : res_idx_q;
    res_data_d = !accept ? res_data_q : any ? ent[win].data : HAS_DEFAULT != 0 ? default_out : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q <= '0;
      res_valid_q <= 1'b0;
      res_hit_q <= 1'b0;
      res_idx_q <= '0;
      res_data_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_valid_q <= res_valid_d;
      res_hit_q <= res_hit_d;
      res_idx_q <= res_idx_d;
      res_data_q <= res_data_d;
    end
  always_ff @(posedge clk) begin
    key_q <= key_d;
    data_q <= data_d;
  end
  assign res_valid = res_valid_q;
  assign res_hit = res_hit_q;
  assign res_idx = res_idx_q;
  assign res_data = res_data_q;
endmodule
